shift_rows_pipe: RTL and testbench

Parametrised, elastic ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. Supports block widths of Nb = 4, 6 or 8 columns and selects forward or inverse direction per beat. Uses a valid/ready handshake with a one-register output stage plus a skid register, so it sustains one beat per cycle under backpressure. It sits between the SubBytes and MixColumns stages of both the encrypt and decrypt round pipelines.

---
 rtl/shift_rows_pipe.sv | 85 ++++++++
 tb/tb_shift_rows_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// Elastic AES ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns.
// A main output register plus a skid register keep one beat per cycle under backpressure.
module shift_rows_pipe #(
   parameter  int NB     = 4,
   parameter  int TAG_W  = 4,
   localparam int DATA_W = 32 * NB
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_inv,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);

   generate
      if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
         $error("shift_rows_pipe: NB must be 4, 6 or 8");
      end
   endgenerate

   logic [DATA_W-1:0] fwd_data;
   logic [DATA_W-1:0] inv_data;
   logic [DATA_W-1:0] shifted;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [TAG_W-1:0]  skid_tag;
   logic              accept;
   logic              drain;

   // Byte 0 is the MSB; rows 2 and 3 shift one extra column when Nb = 8.
   for (genvar k = 0; k < 4 * NB; k++) begin : g_byte
      localparam int R  = k % 4;
      localparam int C  = k / 4;
      localparam int S  = (NB == 8 && R >= 2) ? R + 1 : R;
      localparam int FC = (C + S) % NB;
      localparam int IC = (C - S + NB) % NB;
      assign fwd_data[DATA_W-1-8*k -: 8] = in_data[DATA_W-1-8*(4*FC+R) -: 8];
      assign inv_data[DATA_W-1-8*k -: 8] = in_data[DATA_W-1-8*(4*IC+R) -: 8];
   end

   assign shifted = in_inv ? inv_data : fwd_data;
   assign accept  = in_valid && in_ready;
   assign drain   = out_valid && out_ready;
   assign busy    = out_valid | skid_valid;

   // When main frees up the skid always refills it first, which preserves order.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_tag    <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_tag   <= '0;
         in_ready   <= 1'b1;
      end else if (!out_valid || drain) begin
         if (skid_valid) begin
            out_valid <= 1'b1;
            out_data  <= skid_data;
            out_tag   <= skid_tag;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= shifted;
            out_tag   <= in_tag;
         end else begin
            out_valid <= 1'b0;
         end
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_data  <= shifted;
         skid_tag   <= in_tag;
         in_ready   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: NB=4 instance with a queue-based
// reference of the elastic stage, plus an NB=8 instance for wide-block checks.
module tb_shift_rows_pipe;

   typedef struct {
      logic [127:0] data;
      logic [3:0]   tag;
   } beat_t;

   typedef struct {
      logic         inv;
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
   logic [3:0]   in_tag, out_tag;
   logic [127:0] in_data, out_data;

   logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, busy8;
   logic [3:0]   in_tag8, out_tag8;
   logic [255:0] in_data8, out_data8;

   int compared = 0;
   int mismatched = 0;
   bit mon_en = 1'b0;
   beat_t exp_q[$];
   logic [3:0] exit_tags[$];

   shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
      .in_tag(in_tag), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .busy(busy)
   );

   shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8),
      .in_tag(in_tag8), .in_data(in_data8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .out_data(out_data8), .out_tag(out_tag8), .busy(busy8)
   );

   initial forever #5 clk = ~clk;

   // Reference ShiftRows straight from the row/column definition, right-aligned in 256 bits.
   function automatic logic [255:0] refShift(int nb, logic [255:0] d, logic inv);
      logic [7:0]   b [32];
      logic [7:0]   o [32];
      logic [255:0] res;
      int           offs [4];
      int           src;
      res = '0;
      if (nb == 8) offs = '{0, 1, 3, 4};
      else         offs = '{0, 1, 2, 3};
      for (int k = 0; k < 4 * nb; k++) b[k] = d[32*nb-1-8*k -: 8];
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < nb; c++) begin
            src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
            o[4*c+r] = b[4*src+r];
         end
      end
      for (int k = 0; k < 4 * nb; k++) res[32*nb-1-8*k -: 8] = o[k];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(string name, logic [255:0] act, logic [255:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkBit(string name, logic act, logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(logic v, logic inv, logic [3:0] tag, logic [127:0] d);
      in_valid = v;
      in_inv   = inv;
      in_tag   = tag;
      in_data  = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Occupancy model: the stage holds exp_q.size() beats, at most two.
   always @(negedge clk) begin : monitor
      beat_t        nb;
      logic [255:0] tmp;
      if (mon_en) begin
         checkBit("out_valid", out_valid, exp_q.size() > 0);
         checkBit("busy", busy, exp_q.size() > 0);
         checkBit("in_ready", in_ready, exp_q.size() < 2);
         if (out_valid && exp_q.size() > 0) begin
            checkOutput("out_data", 256'(out_data), 256'(exp_q[0].data));
            checkOutput("out_tag", 256'(out_tag), 256'(exp_q[0].tag));
         end
         if (reset) begin
            exp_q.delete();
         end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
               exit_tags.push_back(out_tag);
               void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
               tmp     = refShift(4, 256'(in_data), in_inv);
               nb.data = tmp[127:0];
               nb.tag  = in_tag;
               exp_q.push_back(nb);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      mismatched++;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin : main
      vec_t         vecs [3];
      logic [255:0] x, y, seq;
      int           idx, cyc;
      logic         acc, d;

      vecs[0] = '{1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
      vecs[1] = '{1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230};
      vecs[2] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};

      applyStimulus(1'b0, 1'b0, 4'h0, '0);
      out_ready  = 1'b1;
      in_valid8  = 1'b0;
      in_inv8    = 1'b0;
      in_tag8    = 4'h0;
      in_data8   = '0;
      out_ready8 = 1'b1;
      reset      = 1'b1;
      step();
      mon_en = 1'b1;
      checkBit("rst_out_valid", out_valid, 1'b0);
      checkBit("rst_in_ready", in_ready, 1'b1);
      checkBit("rst_busy", busy, 1'b0);
      checkOutput("rst_out_data", 256'(out_data), '0);
      step();
      reset = 1'b0;

      $display("[TB] known-answer vectors");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, vecs[i].inv, 4'(i), vecs[i].din);
         step();
         applyStimulus(1'b0, vecs[i].inv, 4'(i), vecs[i].din);
         checkBit("kat_valid", out_valid, 1'b1);
         checkOutput("kat_data", 256'(out_data), 256'(vecs[i].dout));
         step();
      end

      $display("[TB] random traffic with random backpressure");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), rand128());
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      applyStimulus(1'b0, 1'b0, 4'h0, '0);
      out_ready = 1'b1;
      repeat (3) step();

      $display("[TB] backpressure ordering");
      exit_tags.delete();
      idx = 1;
      cyc = 0;
      while (idx <= 6 && cyc < 50) begin
         out_ready = !(cyc >= 2 && cyc <= 4);
         applyStimulus(1'b1, 1'(cyc % 2), idx[3:0], rand128());
         acc = in_valid && in_ready;
         step();
         if (acc) idx++;
         cyc++;
      end
      applyStimulus(1'b0, 1'b0, 4'h0, '0);
      out_ready = 1'b1;
      cyc = 0;
      while (exit_tags.size() < 6 && cyc < 20) begin
         step();
         cyc++;
      end
      checkOutput("bp_exit_count", 256'(exit_tags.size()), 256'(6));
      for (int k = 0; k < 6 && k < exit_tags.size(); k++)
         checkOutput("bp_exit_tag", 256'(exit_tags[k]), 256'(k + 1));

      $display("[TB] continuous 16-beat stream");
      exit_tags.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'(i), rand128());
         step();
         checkBit("stream_valid", out_valid, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, '0);
      step();
      checkOutput("stream_exit_count", 256'(exit_tags.size()), 256'(16));
      checkBit("stream_idle", out_valid, 1'b0);

      $display("[TB] reset with main and skid full");
      out_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 4'hA, rand128());
      step();
      applyStimulus(1'b1, 1'b1, 4'hB, rand128());
      step();
      checkBit("full_in_ready", in_ready, 1'b0);
      checkBit("full_busy", busy, 1'b1);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 4'hF, rand128());
      step();
      checkBit("mid_rst_out_valid", out_valid, 1'b0);
      checkBit("mid_rst_busy", busy, 1'b0);
      checkBit("mid_rst_in_ready", in_ready, 1'b1);
      checkOutput("mid_rst_out_data", 256'(out_data), '0);
      checkOutput("mid_rst_out_tag", 256'(out_tag), '0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0, '0);
      out_ready = 1'b1;
      exit_tags.delete();
      repeat (4) step();
      checkOutput("post_rst_no_exit", 256'(exit_tags.size()), '0);

      $display("[TB] NB=8 checks");
      for (int k = 0; k < 32; k++) seq[255-8*k -: 8] = 8'(k);
      in_valid8 = 1'b1;
      in_inv8   = 1'b0;
      in_data8  = seq;
      step();
      checkBit("nb8_valid", out_valid8, 1'b1);
      checkOutput("nb8_word0", 256'(out_data8[255:224]), 256'(32'h00050e13));
      checkOutput("nb8_full", out_data8, refShift(8, seq, 1'b0));
      for (int i = 0; i < 1000; i++) begin
         x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         d = 1'($urandom_range(0, 1));
         y = refShift(8, x, d);
         in_inv8  = d;
         in_data8 = x;
         in_tag8  = 4'(i);
         step();
         checkOutput("nb8_shift", out_data8, y);
         in_inv8  = !d;
         in_data8 = y;
         step();
         checkOutput("nb8_roundtrip", out_data8, x);
      end
      in_valid8 = 1'b0;
      step();

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
